// File: rtl/sbox_lanes.sv
// Multi-lane AES byte substitution with forward/inverse select, per-lane
// enable mask latched at run start, and a 1..4 stage register pipeline
// carrying a valid flag alongside the data.
module sbox_lanes #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                running,
    input  logic                inv,
    input  logic [DATA_W/8-1:0] lane_en,
    input  logic [DATA_W-1:0]   in0,
    output logic [DATA_W-1:0]   out0,
    output logic                out_valid
);

    localparam int LANES = DATA_W / 8;

    // Reject illegal configurations at elaboration time.
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("sbox_lanes: DATA_W must be a positive multiple of 8");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("sbox_lanes: LATENCY must be in 1..4");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic                inv_q;
    logic [LANES-1:0]    lane_en_q;
    logic                eff_inv;
    logic [LANES-1:0]    eff_en;
    logic [7:0]          lane_byte;
    logic [DATA_W-1:0]   sub_d;
    logic [DATA_W-1:0]   data_q [LATENCY];
    logic [LATENCY-1:0]  valid_q;

    // Substitute every lane using the configuration that applies this cycle;
    // a run pulse takes effect on the word sampled alongside it.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        eff_inv   = run ? inv : inv_q;
        eff_en    = run ? lane_en : lane_en_q;
        lane_byte = '0;
        sub_d     = in0;
        for (int k = 0; k < LANES; k++) begin
            lane_byte = in0[8*k +: 8];
            if (eff_en[k]) begin
                sub_d[8*k +: 8] = eff_inv ? INV_SBOX[lane_byte] : SBOX[lane_byte];
            end
        end
    end

    // Latch direction and lane mask on each run pulse.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            inv_q     <= 1'b0;
            lane_en_q <= '1;
        end else if (run) begin
            inv_q     <= inv;
            lane_en_q <= lane_en;
        end
    end

    // Data stages advance every cycle; reset clears them so out0 reads zero.
    always_ff @(posedge clk) begin
        // NOTE: the data stages are reset explicitly because out0 must read
        // zero after reset; a plain storage array would normally be left
        // unreset.
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= sub_d;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Valid flags follow the data; run drops everything past stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= running;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= run ? 1'b0 : valid_q[i-1];
            end
        end
    end

    assign out0      = data_q[LATENCY-1];
    assign out_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_sbox_lanes.sv
// Self-checking bench for sbox_lanes: three instances (LATENCY 1, 3, 4)
// share one stimulus stream and are compared against a cycle-history model
// whose S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_sbox_lanes;

    logic        clk = 1'b0;
    logic        rst, run, running, inv;
    logic [3:0]  lane_en;
    logic [31:0] in0;
    logic [31:0] out0_1, out0_3, out0_4;
    logic        ov_1, ov_3, ov_4;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sbox_lanes #(.DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .run(run), .running(running), .inv(inv),
        .lane_en(lane_en), .in0(in0), .out0(out0_1), .out_valid(ov_1));
    sbox_lanes #(.DATA_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .run(run), .running(running), .inv(inv),
        .lane_en(lane_en), .in0(in0), .out0(out0_3), .out_valid(ov_3));
    sbox_lanes #(.DATA_W(32), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .running(running), .inv(inv),
        .lane_en(lane_en), .in0(in0), .out0(out0_4), .out_valid(ov_4));

    // ---------------- reference model ----------------
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] g = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
            end
            s = g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] d, input bit iv,
                                             input logic [3:0] en);
        logic [31:0] r = d;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) r[8*k +: 8] = iv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] d;   // substituted word sampled at this edge
        bit          v;   // running at this edge
        bit          rn;  // run pulse at this edge
        bit          rs;  // reset at this edge
    } hist_t;

    hist_t      hist[$];   // hist[0] = most recent edge
    bit         m_inv;
    logic [3:0] m_en;

    task automatic model_edge();
        hist_t h;
        h.d = '0; h.v = 0; h.rn = 0; h.rs = 0;
        if (rst) begin
            h.rs  = 1;
            m_inv = 0;
            m_en  = 4'hF;
        end else begin
            h.d  = sub_word(in0, run ? inv : m_inv, run ? lane_en : m_en);
            h.v  = running;
            h.rn = run;
            if (run) begin
                m_inv = inv;
                m_en  = lane_en;
            end
        end
        hist.push_front(h);
        if (hist.size() > 8) void'(hist.pop_back());
    endtask

    // Word seen at the output L edges after sampling; lost to a reset in that
    // window, invalidated by any later run pulse before it reaches the output.
    task automatic model_out(input int lat, output logic [31:0] d, output logic v);
        bit rs = 0;
        bit kill = 0;
        for (int j = 0; j < lat; j++) if (hist[j].rs) rs = 1;
        for (int j = 0; j < lat - 1; j++) if (hist[j].rn) kill = 1;
        if (rs) begin
            d = '0;
            v = 1'b0;
        end else begin
            d = hist[lat-1].d;
            v = hist[lat-1].v && !kill;
        end
    endtask

    // ---------------- checking ----------------
    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        logic [31:0] d;
        logic        v;
        model_out(1, d, v);
        ck("L1 out0", out0_1, d);  ck("L1 out_valid", 32'(ov_1), 32'(v));
        model_out(3, d, v);
        ck("L3 out0", out0_3, d);  ck("L3 out_valid", 32'(ov_3), 32'(v));
        model_out(4, d, v);
        ck("L4 out0", out0_4, d);  ck("L4 out_valid", 32'(ov_4), 32'(v));
    endtask

    task automatic cycle(input bit r, input bit rn, input bit rg, input bit iv,
                         input logic [3:0] le, input logic [31:0] d);
        rst = r; run = rn; running = rg; inv = iv; lane_en = le; in0 = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_models();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        hist_t pad;
        pad.d = '0; pad.v = 0; pad.rn = 0; pad.rs = 1;
        for (int i = 0; i < 4; i++) hist.push_back(pad);
        m_inv = 0;
        m_en  = 4'hF;
        build_tables();

        // Reset with busy inputs, then release and stream.
        cycle(1, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        cycle(1, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        ck("rst out0", out0_4, 32'h0);
        ck("rst out_valid", 32'(ov_4), 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 4'h0, 32'(i * 32'h0101_0101));

        // Forward, all lanes; inv toggles while run=0 must be ignored.
        cycle(0, 1, 0, 0, 4'hF, 32'h0);
        cycle(0, 0, 1, 1, 4'h0, 32'h0053_01FF);
        ck("fwd word", out0_1, 32'h63ED_7C16);
        ck("fwd valid", 32'(ov_1), 32'h1);

        // Inverse round-trip; config applies in the run cycle itself.
        cycle(0, 1, 1, 1, 4'hF, 32'h63ED_7C16);
        ck("inv word", out0_1, 32'h0053_01FF);
        cycle(0, 0, 1, 0, 4'h3, 32'h0);
        ck("inv zero", out0_1, 32'h5252_5252);

        // Lane mask 0101.
        cycle(0, 1, 0, 0, 4'b0101, 32'h0);
        cycle(0, 0, 1, 1, 4'hF, 32'h0053_01FF);
        ck("mask word", out0_1, 32'h00ED_0116);

        // Config isolation and 3-cycle latency.
        cycle(0, 1, 0, 0, 4'hF, 32'h0);
        cycle(0, 0, 1, 0, 4'h0, 32'h0000_0000);
        cycle(0, 0, 1, 1, 4'h0, 32'h0101_0101);
        cycle(0, 0, 1, 0, 4'h0, 32'hFFFF_FFFF);
        ck("L3 first", out0_3, 32'h6363_6363);
        cycle(0, 0, 0, 1, 4'h0, 32'h0);
        ck("L3 second", out0_3, 32'h7C7C_7C7C);
        cycle(0, 0, 0, 0, 4'h0, 32'h0);
        ck("L3 third", out0_3, 32'h1616_1616);
        ck("L3 third valid", 32'(ov_3), 32'h1);

        // Flush on LATENCY=4: three slots invalid, run-cycle word survives.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 4'h0, $urandom);
        cycle(0, 1, 1, 1, 4'hF, 32'h0);
        ck("flush slot1", 32'(ov_4), 32'h0);
        cycle(0, 0, 1, 0, 4'h0, $urandom);
        ck("flush slot2", 32'(ov_4), 32'h0);
        cycle(0, 0, 1, 0, 4'h0, $urandom);
        ck("flush slot3", 32'(ov_4), 32'h0);
        cycle(0, 0, 1, 0, 4'h0, $urandom);
        ck("flush survivor", out0_4, 32'h5252_5252);
        ck("flush survivor valid", 32'(ov_4), 32'h1);

        // Reset mid-stream.
        cycle(0, 0, 1, 0, 4'h0, $urandom);
        cycle(1, 1, 1, 1, 4'h0, $urandom);
        ck("midrst out0", out0_4, 32'h0);
        ck("midrst valid", 32'(ov_4), 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 4'h0, $urandom);

        // Sweep every byte value through both tables.
        cycle(0, 1, 1, 0, 4'hF, 32'h0);
        for (int i = 0; i < 64; i++)
            cycle(0, 0, 1, 0, 4'h0, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        cycle(0, 1, 1, 1, 4'hF, 32'h0);
        for (int i = 0; i < 64; i++)
            cycle(0, 0, 1, 0, 4'h0, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});

        // Random traffic with occasional run pulses and resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 50) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
                  1'($urandom), 4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
